// File: rtl/ps2_scancode_decoder_if.sv
// rtl/ps2_scancode_decoder_if.sv - key event valid/ready bus between decoder and consumer
interface ps2_scancode_decoder_if;
    logic       key_valid;
    logic       key_ready;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_break;
    logic [7:0] key_ascii;

    modport master (
        output key_valid,
        output key_code,
        output key_ext,
        output key_break,
        output key_ascii,
        input  key_ready
    );

    modport slave (
        input  key_valid,
        input  key_code,
        input  key_ext,
        input  key_break,
        input  key_ascii,
        output key_ready
    );
endinterface

// File: rtl/ps2_scancode_decoder.sv
// rtl/ps2_scancode_decoder.sv - set-2 scan code byte stream to key events with modifier tracking
module ps2_scancode_decoder #(
    parameter int ASCII_EN   = 1,
    parameter int PAUSE_SKIP = 7
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [7:0] kb_data,
    input  logic       kb_ready,
    input  logic       kb_overflow,
    output logic       kb_nextdata_,
    ps2_scancode_decoder_if.master key,
    output logic       shift,
    output logic       ctrl,
    output logic       caps_lock,
    output logic       err
);
    localparam int SKIP_W = (PAUSE_SKIP < 2) ? 1 : $clog2(PAUSE_SKIP + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_POP    = 2'd1;
    localparam logic [1:0] S_DECODE = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [7:0]        byte_q, byte_d;
    logic              nextdata_q, nextdata_d;
    logic              valid_q, valid_d;
    logic [7:0]        code_q, code_d;
    logic              ext_q, ext_d;
    logic              brk_q, brk_d;
    logic [7:0]        ascii_q, ascii_d;
    logic              ext_pend_q, ext_pend_d;
    logic              brk_pend_q, brk_pend_d;
    logic [SKIP_W-1:0] skip_q, skip_d;
    logic              lshift_q, lshift_d;
    logic              rshift_q, rshift_d;
    logic              lctrl_q, lctrl_d;
    logic              rctrl_q, rctrl_d;
    logic              caps_held_q, caps_held_d;
    logic              caps_q, caps_d;
    logic              err_q, err_d;

    logic              emit;
    logic [7:0]        e_code;
    logic              e_ext;
    logic              e_brk;

    // Translation uses the modifier state in effect before this event is applied.
    function automatic logic [7:0] ascii_of(input logic [7:0] code, input logic ext,
                                            input logic brk, input logic sh, input logic cl);
        logic [7:0] lc;
        logic [7:0] dg;
        logic [7:0] ds;
        logic [7:0] res;
        lc  = 8'h00;
        dg  = 8'h00;
        ds  = 8'h00;
        res = 8'h00;
        case (code)
            8'h1C: lc = "a";  8'h32: lc = "b";  8'h21: lc = "c";  8'h23: lc = "d";
            8'h24: lc = "e";  8'h2B: lc = "f";  8'h34: lc = "g";  8'h33: lc = "h";
            8'h43: lc = "i";  8'h3B: lc = "j";  8'h42: lc = "k";  8'h4B: lc = "l";
            8'h3A: lc = "m";  8'h31: lc = "n";  8'h44: lc = "o";  8'h4D: lc = "p";
            8'h15: lc = "q";  8'h2D: lc = "r";  8'h1B: lc = "s";  8'h2C: lc = "t";
            8'h3C: lc = "u";  8'h2A: lc = "v";  8'h1D: lc = "w";  8'h22: lc = "x";
            8'h35: lc = "y";  8'h1A: lc = "z";
            default: lc = 8'h00;
        endcase
        case (code)
            8'h16: begin dg = "1"; ds = "!"; end
            8'h1E: begin dg = "2"; ds = "@"; end
            8'h26: begin dg = "3"; ds = "#"; end
            8'h25: begin dg = "4"; ds = "$"; end
            8'h2E: begin dg = "5"; ds = "%"; end
            8'h36: begin dg = "6"; ds = "^"; end
            8'h3D: begin dg = "7"; ds = "&"; end
            8'h3E: begin dg = "8"; ds = "*"; end
            8'h46: begin dg = "9"; ds = "("; end
            8'h45: begin dg = "0"; ds = ")"; end
            default: begin dg = 8'h00; ds = 8'h00; end
        endcase
        if (brk) begin
            res = 8'h00;
        end else if (ext) begin
            res = (code == 8'h5A) ? 8'h0D : 8'h00;
        end else if (lc != 8'h00) begin
            res = (sh ^ cl) ? (lc - 8'h20) : lc;
        end else if (dg != 8'h00) begin
            res = sh ? ds : dg;
        end else begin
            case (code)
                8'h29:   res = 8'h20;
                8'h5A:   res = 8'h0D;
                8'h66:   res = 8'h08;
                8'h0D:   res = 8'h09;
                8'h76:   res = 8'h1B;
                default: res = 8'h00;
            endcase
        end
        return res;
    endfunction

    always_comb begin
        state_d     = state_q;
        byte_d      = byte_q;
        nextdata_d  = nextdata_q;
        valid_d     = valid_q;
        code_d      = code_q;
        ext_d       = ext_q;
        brk_d       = brk_q;
        ascii_d     = ascii_q;
        ext_pend_d  = ext_pend_q;
        brk_pend_d  = brk_pend_q;
        skip_d      = skip_q;
        lshift_d    = lshift_q;
        rshift_d    = rshift_q;
        lctrl_d     = lctrl_q;
        rctrl_d     = rctrl_q;
        caps_held_d = caps_held_q;
        caps_d      = caps_q;
        err_d       = err_q | kb_overflow;
        emit        = 1'b0;
        e_code      = byte_q;
        e_ext       = ext_pend_q;
        e_brk       = brk_pend_q;

        if (valid_q && key.key_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (kb_ready && (!valid_q || key.key_ready)) begin
                    byte_d     = kb_data;
                    nextdata_d = 1'b0;
                    state_d    = S_POP;
                end
            end
            S_POP: begin
                nextdata_d = 1'b1;
                state_d    = S_DECODE;
            end
            S_DECODE: begin
                state_d = S_IDLE;
                if (skip_q != '0) begin
                    skip_d = skip_q - SKIP_W'(1);
                    if (skip_q == SKIP_W'(1)) begin
                        emit   = 1'b1;
                        e_code = 8'hE1;
                        e_ext  = 1'b0;
                        e_brk  = 1'b0;
                    end
                end else begin
                    case (byte_q)
                        8'hE0: ext_pend_d = 1'b1;
                        8'hF0: brk_pend_d = 1'b1;
                        8'hE1: begin
                            skip_d     = SKIP_W'(PAUSE_SKIP);
                            ext_pend_d = 1'b0;
                            brk_pend_d = 1'b0;
                        end
                        8'hAA, 8'hFA, 8'hEE, 8'hFE: begin
                            ext_pend_d = 1'b0;
                            brk_pend_d = 1'b0;
                        end
                        8'h00, 8'hFF: begin
                            ext_pend_d = 1'b0;
                            brk_pend_d = 1'b0;
                            err_d      = 1'b1;
                        end
                        default: begin
                            emit       = 1'b1;
                            ext_pend_d = 1'b0;
                            brk_pend_d = 1'b0;
                        end
                    endcase
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (emit) begin
            valid_d = 1'b1;
            code_d  = e_code;
            ext_d   = e_ext;
            brk_d   = e_brk;
            ascii_d = (ASCII_EN != 0) ? ascii_of(e_code, e_ext, e_brk, lshift_q | rshift_q, caps_q)
                                      : 8'h00;
            if (e_code == 8'h12 && !e_ext) lshift_d = !e_brk;
            if (e_code == 8'h59 && !e_ext) rshift_d = !e_brk;
            if (e_code == 8'h14 && !e_ext) lctrl_d  = !e_brk;
            if (e_code == 8'h14 &&  e_ext) rctrl_d  = !e_brk;
            // Typematic repeats of caps lock arrive as makes while already held.
            if (e_code == 8'h58 && !e_ext) begin
                caps_held_d = !e_brk;
                if (!e_brk && !caps_held_q) caps_d = !caps_q;
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q     <= S_IDLE;
            byte_q      <= 8'h00;
            nextdata_q  <= 1'b1;
            valid_q     <= 1'b0;
            code_q      <= 8'h00;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            ascii_q     <= 8'h00;
            ext_pend_q  <= 1'b0;
            brk_pend_q  <= 1'b0;
            skip_q      <= '0;
            lshift_q    <= 1'b0;
            rshift_q    <= 1'b0;
            lctrl_q     <= 1'b0;
            rctrl_q     <= 1'b0;
            caps_held_q <= 1'b0;
            caps_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_q      <= byte_d;
            nextdata_q  <= nextdata_d;
            valid_q     <= valid_d;
            code_q      <= code_d;
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            ascii_q     <= ascii_d;
            ext_pend_q  <= ext_pend_d;
            brk_pend_q  <= brk_pend_d;
            skip_q      <= skip_d;
            lshift_q    <= lshift_d;
            rshift_q    <= rshift_d;
            lctrl_q     <= lctrl_d;
            rctrl_q     <= rctrl_d;
            caps_held_q <= caps_held_d;
            caps_q      <= caps_d;
            err_q       <= err_d;
        end
    end

    assign kb_nextdata_  = nextdata_q;
    assign key.key_valid = valid_q;
    assign key.key_code  = code_q;
    assign key.key_ext   = ext_q;
    assign key.key_break = brk_q;
    assign key.key_ascii = ascii_q;
    assign shift         = lshift_q | rshift_q;
    assign ctrl          = lctrl_q | rctrl_q;
    assign caps_lock     = caps_q;
    assign err           = err_q;
endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// tb/tb_ps2_scancode_decoder.sv - randomized bench for ps2_scancode_decoder against a key-event model
module tb_ps2_scancode_decoder;
    logic       clk = 1'b0;
    logic       clr;
    logic [7:0] kb_data = 8'h00;
    logic       kb_ready = 1'b0;
    logic       kb_overflow;
    logic       kb_nextdata_;
    logic       shift, ctrl, caps_lock, err;

    ps2_scancode_decoder_if kif();

    ps2_scancode_decoder #(.ASCII_EN(1), .PAUSE_SKIP(7)) dut (
        .clk          (clk),
        .clr          (clr),
        .kb_data      (kb_data),
        .kb_ready     (kb_ready),
        .kb_overflow  (kb_overflow),
        .kb_nextdata_ (kb_nextdata_),
        .key          (kif),
        .shift        (shift),
        .ctrl         (ctrl),
        .caps_lock    (caps_lock),
        .err          (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
        logic [7:0] ascii;
        logic       sh;
        logic       ct;
        logic       cp;
    } ev_t;

    ev_t        got[$];
    ev_t        exp_q[$];
    logic [7:0] fifo[$];
    int         pop_cyc[$];
    int         checks = 0;
    int         errors = 0;
    int         pop_count = 0;
    int         underflow = 0;
    int         cyc = 0;

    // Upstream FIFO: head is consumed on each edge that sees the pop strobe low.
    always @(posedge clk) begin
        cyc++;
        if (!kb_nextdata_) begin
            pop_count++;
            pop_cyc.push_back(cyc);
            if (fifo.size() > 0) void'(fifo.pop_front());
            else underflow++;
        end
        #1;
        kb_ready = (fifo.size() != 0);
        kb_data  = kb_ready ? fifo[0] : 8'h00;
    end

    always @(negedge clk) begin
        if (!clr && kif.key_valid && kif.key_ready)
            got.push_back({kif.key_code, kif.key_ext, kif.key_break, kif.key_ascii,
                           shift, ctrl, caps_lock});
    end

    // Reference model: held-key set indexed by {ext, code}.
    bit         held [512];
    logic       m_ext, m_brk, m_caps, m_err;
    int         m_skip;
    logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                                      8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                                      8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                      8'h35, 8'h1A};
    logic [7:0] digit_codes [10] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E,
                                     8'h46, 8'h45};
    string lower_s = "abcdefghijklmnopqrstuvwxyz";
    string upper_s = "ABCDEFGHIJKLMNOPQRSTUVWXYZ";
    string digit_s = "1234567890";
    string sym_s   = "!@#$%^&*()";

    function automatic logic m_shift();
        return held[9'h012] | held[9'h059];
    endfunction

    function automatic logic m_ctrl();
        return held[9'h014] | held[9'h114];
    endfunction

    function automatic logic [7:0] model_ascii(logic [7:0] c, logic e, logic b, logic sh, logic cl);
        if (b) return 8'h00;
        if (e) return (c == 8'h5A) ? 8'h0D : 8'h00;
        for (int i = 0; i < 26; i++)
            if (letter_codes[i] == c) return (sh ^ cl) ? upper_s[i] : lower_s[i];
        for (int i = 0; i < 10; i++)
            if (digit_codes[i] == c) return sh ? sym_s[i] : digit_s[i];
        case (c)
            8'h29: return 8'h20;
            8'h5A: return 8'h0D;
            8'h66: return 8'h08;
            8'h0D: return 8'h09;
            8'h76: return 8'h1B;
            default: return 8'h00;
        endcase
    endfunction

    function automatic void model_reset();
        foreach (held[i]) held[i] = 1'b0;
        m_ext = 0; m_brk = 0; m_caps = 0; m_err = 0; m_skip = 0;
    endfunction

    function automatic void model_byte(logic [7:0] b);
        logic [7:0] a;
        if (m_skip > 0) begin
            m_skip--;
            if (m_skip == 0) exp_q.push_back({8'hE1, 1'b0, 1'b0, 8'h00, m_shift(), m_ctrl(), m_caps});
            return;
        end
        if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else if (b == 8'hE1) begin m_skip = 7; m_ext = 0; m_brk = 0; end
        else if (b inside {8'hAA, 8'hFA, 8'hEE, 8'hFE}) begin m_ext = 0; m_brk = 0; end
        else if (b inside {8'h00, 8'hFF}) begin m_ext = 0; m_brk = 0; m_err = 1; end
        else begin
            a = model_ascii(b, m_ext, m_brk, m_shift(), m_caps);
            if (b == 8'h58 && !m_ext && !m_brk && !held[9'h058]) m_caps = !m_caps;
            held[{m_ext, b}] = !m_brk;
            exp_q.push_back({b, m_ext, m_brk, a, m_shift(), m_ctrl(), m_caps});
            m_ext = 0; m_brk = 0;
        end
    endfunction

    task automatic push(input logic [7:0] b);
        fifo.push_back(b);
        model_byte(b);
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        clr = 1; fifo.delete(); kb_overflow = 0; kif.key_ready = 1;
        @(posedge clk); #2;
        clr = 0;
        got.delete(); exp_q.delete(); pop_cyc.delete();
        pop_count = 0; underflow = 0;
        model_reset();
    endtask

    task automatic drain(input string name);
        int quiet = 0;
        kif.key_ready = 1;
        for (int i = 0; i < 3000 && quiet < 6; i++) begin
            @(posedge clk); #2;
            if (fifo.size() == 0 && !kif.key_valid) quiet++;
            else quiet = 0;
        end
        checks++;
        if (quiet < 6) begin
            errors++;
            $display("FAIL %s_drain_timeout fifo_left=%0d required=0", name, fifo.size());
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({kb_nextdata_, kif.key_valid, kif.key_code, kif.key_ext, kif.key_break, kif.key_ascii,
             shift, ctrl, caps_lock, err} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 4'b0000}) begin
            errors++;
            $display("FAIL reset_state nextdata=%b valid=%b code=%h flags=%b%b%b%b required nextdata=1 rest 0",
                     kb_nextdata_, kif.key_valid, kif.key_code, shift, ctrl, caps_lock, err);
        end
        do_reset();
        push(8'h1C);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!kb_nextdata_) break;
        end
        #1 clr = 1;
        #1;
        checks++;
        if ({kb_nextdata_, kif.key_valid, shift, ctrl, caps_lock, err} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_async nextdata=%b valid=%b flags=%b%b%b%b required nextdata=1 rest 0",
                     kb_nextdata_, kif.key_valid, shift, ctrl, caps_lock, err);
        end
        @(posedge clk); #2;
        clr = 0;
        drain("reset");
        checks++;
        if (got.size() !== 1 || pop_count !== 1) begin
            errors++;
            $display("FAIL reset_events events=%0d pops=%0d required 1 and 1", got.size(), pop_count);
        end else begin
            checks++;
            if (got[0] !== exp_q[0] || got[0].ascii !== 8'h61) begin
                errors++;
                $display("FAIL reset_event got=%h required=%h", got[0], exp_q[0]);
            end
        end
    endtask

    task automatic test_shift();
        logic [7:0] seq [6] = '{8'h12, 8'h1C, 8'hF0, 8'h1C, 8'hF0, 8'h12};
        do_reset();
        foreach (seq[i]) push(seq[i]);
        drain("shift");
        checks++;
        if (got.size() !== 4) begin
            errors++;
            $display("FAIL shift_count got=%0d required=4", got.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL shift_event%0d got=%h required=%h", i, got[i], exp_q[i]);
                end
            end
            checks++;
            if ({got[0].sh, got[1].ascii, got[2].ascii, got[3].sh} !== {1'b1, 8'h41, 8'h00, 1'b0}) begin
                errors++;
                $display("FAIL shift_fixed sh0=%b a1=%h a2=%h sh3=%b required 1 41 00 0",
                         got[0].sh, got[1].ascii, got[2].ascii, got[3].sh);
            end
        end
    endtask

    task automatic test_caps();
        logic [7:0] seq [5] = '{8'h58, 8'h58, 8'hF0, 8'h58, 8'h1C};
        do_reset();
        foreach (seq[i]) push(seq[i]);
        drain("caps");
        checks++;
        if (got.size() !== 4) begin
            errors++;
            $display("FAIL caps_count got=%0d required=4", got.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL caps_event%0d got=%h required=%h", i, got[i], exp_q[i]);
                end
            end
            checks++;
            if ({got[0].cp, got[1].cp, got[2].cp, got[3].ascii, caps_lock} !== {3'b111, 8'h41, 1'b1}) begin
                errors++;
                $display("FAIL caps_fixed cp=%b%b%b a3=%h caps=%b required 111 41 1",
                         got[0].cp, got[1].cp, got[2].cp, got[3].ascii, caps_lock);
            end
        end
    endtask

    task automatic test_ext();
        logic [7:0] seq [8] = '{8'hE0, 8'hF0, 8'h75, 8'hE0, 8'h5A, 8'hF0, 8'hE0, 8'h75};
        do_reset();
        foreach (seq[i]) push(seq[i]);
        drain("ext");
        checks++;
        if (got.size() !== 3) begin
            errors++;
            $display("FAIL ext_count got=%0d required=3", got.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (got[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL ext_event%0d got=%h required=%h", i, got[i], exp_q[i]);
                end
            end
            checks++;
            if ({got[0].code, got[0].ext, got[0].brk, got[1].ascii, got[2].ext, got[2].brk}
                !== {8'h75, 2'b11, 8'h0D, 2'b11}) begin
                errors++;
                $display("FAIL ext_fixed c0=%h e0=%b b0=%b a1=%h e2=%b b2=%b required 75 1 1 0d 1 1",
                         got[0].code, got[0].ext, got[0].brk, got[1].ascii, got[2].ext, got[2].brk);
            end
        end
    endtask

    task automatic test_pause();
        logic [7:0] seq [9] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h1C};
        do_reset();
        foreach (seq[i]) push(seq[i]);
        drain("pause");
        checks++;
        if (got.size() !== 2) begin
            errors++;
            $display("FAIL pause_count got=%0d required=2", got.size());
        end else begin
            checks++;
            if (got[0] !== exp_q[0] || got[0].code !== 8'hE1 || got[0].brk !== 1'b0) begin
                errors++;
                $display("FAIL pause_event got=%h required=%h", got[0], exp_q[0]);
            end
            checks++;
            if (got[1] !== exp_q[1]) begin
                errors++;
                $display("FAIL pause_after got=%h required=%h", got[1], exp_q[1]);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        kif.key_ready = 0;
        push(8'h16);
        push(8'h1E);
        repeat (20) @(posedge clk);
        #2;
        checks++;
        if ({kif.key_valid, kif.key_code} !== {1'b1, 8'h16} || fifo.size() !== 1 || pop_count !== 1) begin
            errors++;
            $display("FAIL bp_hold valid=%b code=%h fifo=%0d pops=%0d required 1 16 1 1",
                     kif.key_valid, kif.key_code, fifo.size(), pop_count);
        end
        drain("bp");
        checks++;
        if (got.size() !== 2) begin
            errors++;
            $display("FAIL bp_count got=%0d required=2", got.size());
        end else begin
            checks++;
            if (got[0] !== exp_q[0] || got[1] !== exp_q[1] || got[1].ascii !== 8'h32) begin
                errors++;
                $display("FAIL bp_events got=%h %h required=%h %h", got[0], got[1], exp_q[0], exp_q[1]);
            end
        end
    endtask

    task automatic test_err();
        do_reset();
        push(8'h00);
        drain("err");
        checks++;
        if (err !== 1'b1 || got.size() !== 0) begin
            errors++;
            $display("FAIL err_byte err=%b events=%0d required 1 0", err, got.size());
        end
        push(8'h1C);
        drain("err2");
        checks++;
        if (err !== 1'b1 || got.size() !== 1) begin
            errors++;
            $display("FAIL err_sticky err=%b events=%0d required 1 1", err, got.size());
        end
        do_reset();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_clear err=%b required=0", err);
        end
        kb_overflow = 1;
        @(posedge clk); #2;
        kb_overflow = 0;
        repeat (5) @(posedge clk);
        #2;
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_overflow err=%b required=1", err);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq [5] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E};
        do_reset();
        foreach (seq[i]) push(seq[i]);
        drain("b2b");
        checks++;
        if (pop_cyc.size() !== 5 || underflow !== 0) begin
            errors++;
            $display("FAIL b2b_pops pops=%0d underflow=%0d required 5 0", pop_cyc.size(), underflow);
        end else begin
            for (int i = 1; i < 5; i++) begin
                checks++;
                if (pop_cyc[i] - pop_cyc[i-1] !== 3) begin
                    errors++;
                    $display("FAIL b2b_spacing%0d got=%0d required=3", i, pop_cyc[i] - pop_cyc[i-1]);
                end
            end
        end
        checks++;
        if (got !== exp_q) begin
            errors++;
            $display("FAIL b2b_events got_n=%0d required_n=%0d", got.size(), exp_q.size());
        end
    endtask

    function automatic logic [7:0] pick_byte();
        int r = $urandom_range(0, 99);
        logic [7:0] mods   [4] = '{8'h12, 8'h59, 8'h14, 8'h58};
        logic [7:0] others [12] = '{8'h1C, 8'h32, 8'h16, 8'h45, 8'h29, 8'h5A, 8'h66,
                                    8'h0D, 8'h76, 8'h75, 8'h7C, 8'h1A};
        logic [7:0] acks   [4] = '{8'hAA, 8'hFA, 8'hEE, 8'hFE};
        if (r < 15) return 8'hE0;
        if (r < 28) return 8'hF0;
        if (r < 30) return 8'hE1;
        if (r < 33) return acks[$urandom_range(0, 3)];
        if (r < 34) return ($urandom_range(0, 1) != 0) ? 8'h00 : 8'hFF;
        if (r < 60) return mods[$urandom_range(0, 3)];
        if (r < 90) return others[$urandom_range(0, 11)];
        return 8'($urandom_range(1, 254));
    endfunction

    task automatic test_random();
        int left = 400;
        do_reset();
        for (int c = 0; c < 20000 && left > 0; c++) begin
            @(posedge clk); #2;
            kif.key_ready = ($urandom_range(0, 3) != 0);
            if (fifo.size() < 4 && $urandom_range(0, 1) != 0) begin
                push(pick_byte());
                left--;
            end
        end
        drain("rand");
        checks++;
        if (got.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL rand_count got=%0d required=%0d", got.size(), exp_q.size());
        end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL rand_event%0d got=%h required=%h", i, got[i], exp_q[i]);
            end
        end
        checks++;
        if ({shift, ctrl, caps_lock, err} !== {m_shift(), m_ctrl(), m_caps, m_err}) begin
            errors++;
            $display("FAIL rand_state got=%b%b%b%b required=%b%b%b%b", shift, ctrl, caps_lock, err,
                     m_shift(), m_ctrl(), m_caps, m_err);
        end
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog_timeout time=%0t required=finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        clr = 1;
        kb_overflow = 0;
        kif.key_ready = 1;
        model_reset();
        test_reset();
        test_shift();
        test_caps();
        test_ext();
        test_pause();
        test_backpressure();
        test_err();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
